oldland_imem: RTL and testbench

//  On-chip instruction memory: the responder for the fetch port. Every cycle it takes the

---
 rtl/oldland_imem_pkg.sv | 34 +++
 rtl/oldland_imem_ram.sv | 46 ++++
 rtl/oldland_imem.sv | 165 ++++++++++++++++
 tb/tb_oldland_imem.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/oldland_imem_pkg.sv
// +----------------------------------------------------------------------------+
// | oldland_imem_pkg : shared constants, types and helpers for the instruction |
// | memory. Revision: 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef INSTR_NOP
`define INSTR_NOP 32'h18000000
`endif
`ifndef OLDLAND_IMEM_ADDR_BITS
`define OLDLAND_IMEM_ADDR_BITS 12
`endif

package oldland_imem_pkg;

  localparam logic [31:0] IMEM_NOP               = `INSTR_NOP;
  localparam int unsigned IMEM_DEFAULT_ADDR_BITS = `OLDLAND_IMEM_ADDR_BITS;

  // Source of the word presented on fetch_data in the next cycle.
  typedef enum logic [1:0] {
    FSEL_NOP = 2'd0,
    FSEL_RAM = 2'd1,
    FSEL_BYP = 2'd2
  } fetch_sel_e;

  function automatic logic addr_in_range(input logic [29:0] a,
                                         input logic [29:0] base,
                                         input int unsigned abits);
    return (a >> abits) == (base >> abits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/oldland_imem_ram.sv
// +----------------------------------------------------------------------------+
// | oldland_imem_ram : 2^ADDR_BITS x 32 array, one synchronous write port and  |
// | two enabled synchronous read ports, no reset. Revision: 1.0                |
// +----------------------------------------------------------------------------+
`default_nettype none

module oldland_imem_ram #(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic                 re0_i,
  input  logic [ADDR_BITS-1:0] raddr0_i,
  output logic [31:0]          rdata0_o,
  input  logic                 re1_i,
  input  logic [ADDR_BITS-1:0] raddr1_i,
  output logic [31:0]          rdata1_o
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem_q [0:DEPTH-1];
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  // Read-first on both read ports; the parent provides write-first bypass.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re0_i) begin
      rdata0_q <= mem_q[raddr0_i];
    end
    if (re1_i) begin
      rdata1_q <= mem_q[raddr1_i];
    end
  end

  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

`default_nettype wire

// File: rtl/oldland_imem.sv
// +----------------------------------------------------------------------------+
// | oldland_imem : on-chip instruction memory with a latency-1 fetch port, a   |
// | handshaked debug port and a NOP fill after reset. Revision: 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

module oldland_imem
  import oldland_imem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = IMEM_DEFAULT_ADDR_BITS,
  parameter logic [29:0] BASE_ADDR = 30'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        init_done,
  input  logic        dbg_req,
  input  logic        dbg_wr,
  input  logic [29:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack
);

  localparam logic [2:0] ST_CLEAR  = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_DROP   = 3'd4;

  localparam logic [ADDR_BITS:0] CTR_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  logic [2:0]           state_q, state_d;
  logic [ADDR_BITS:0]   clr_ctr_q, clr_ctr_d;
  logic                 init_done_q, init_done_d;
  fetch_sel_e           fsel_q, fsel_d;
  logic [31:0]          byp_data_q, byp_data_d;
  logic                 rd_sel_q, rd_sel_d;

  logic                 fetch_hit;
  logic                 dbg_hit;
  logic [ADDR_BITS-1:0] fetch_idx;
  logic [ADDR_BITS-1:0] dbg_idx;
  logic                 dbg_wr_en;
  logic                 dbg_rd_en;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_waddr;
  logic [31:0]          ram_wdata;
  logic [31:0]          ram_rdata0;
  logic [31:0]          ram_rdata1;

  assign fetch_hit = addr_in_range(fetch_addr, BASE_ADDR, ADDR_BITS);
  assign dbg_hit   = addr_in_range(dbg_addr, BASE_ADDR, ADDR_BITS);
  assign fetch_idx = fetch_addr[ADDR_BITS-1:0];
  assign dbg_idx   = dbg_addr[ADDR_BITS-1:0];

  assign dbg_wr_en = (state_q == ST_ACCESS) && dbg_wr && dbg_hit;
  assign dbg_rd_en = (state_q == ST_ACCESS) && !dbg_wr;

  assign ram_we    = (state_q == ST_CLEAR) || dbg_wr_en;
  assign ram_waddr = (state_q == ST_CLEAR) ? clr_ctr_q[ADDR_BITS-1:0] : dbg_idx;
  assign ram_wdata = (state_q == ST_CLEAR) ? IMEM_NOP : dbg_wdata;

  oldland_imem_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk      (clk),
    .we_i     (ram_we),
    .waddr_i  (ram_waddr),
    .wdata_i  (ram_wdata),
    .re0_i    (1'b1),
    .raddr0_i (fetch_idx),
    .rdata0_o (ram_rdata0),
    .re1_i    (dbg_rd_en),
    .raddr1_i (dbg_idx),
    .rdata1_o (ram_rdata1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_ctr_q   <= '0;
      init_done_q <= 1'b0;
      fsel_q      <= FSEL_NOP;
      byp_data_q  <= '0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ctr_q   <= clr_ctr_d;
      init_done_q <= init_done_d;
      fsel_q      <= fsel_d;
      byp_data_q  <= byp_data_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_ctr_d   = clr_ctr_q;
    init_done_d = init_done_q;
    rd_sel_d    = rd_sel_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_ctr_d = clr_ctr_q + CTR_ONE;
        if (clr_ctr_d[ADDR_BITS]) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (dbg_req) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Read data stays selected until the next read replaces it.
        if (!dbg_wr) begin
          rd_sel_d = dbg_hit;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_DROP;
      end
      ST_DROP: begin
        if (!dbg_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Fetch source selection, including write-first bypass on an index collision.
  always_comb begin
    fsel_d     = FSEL_NOP;
    byp_data_d = dbg_wdata;
    if (init_done_q && fetch_hit) begin
      if (dbg_wr_en && (dbg_idx == fetch_idx)) begin
        fsel_d = FSEL_BYP;
      end else begin
        fsel_d = FSEL_RAM;
      end
    end
  end

  always_comb begin
    fetch_data = IMEM_NOP;
    case (fsel_q)
      FSEL_RAM: fetch_data = ram_rdata0;
      FSEL_BYP: fetch_data = byp_data_q;
      default:  fetch_data = IMEM_NOP;
    endcase
  end

  assign dbg_rdata = rd_sel_q ? ram_rdata1 : 32'h0;
  assign dbg_ack   = (state_q == ST_ACK);
  assign init_done = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_oldland_imem.sv
// +----------------------------------------------------------------------------+
// | tb_oldland_imem : scoreboard bench for the instruction memory fetch and    |
// | debug ports. Revision: 1.0                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_oldland_imem;

  localparam logic [31:0] NOP   = 32'h18000000;
  localparam int          WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        init_done;
  logic        dbg_req;
  logic        dbg_wr;
  logic [29:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [int];
  logic [31:0] fetch_q [$];
  logic [31:0] dbg_q [$];

  always #5 clk = ~clk;

  oldland_imem dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .init_done  (init_done),
    .dbg_req    (dbg_req),
    .dbg_wr     (dbg_wr),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata),
    .dbg_ack    (dbg_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [29:0] a);
    return a < 30'(WORDS);
  endfunction

  function automatic logic [31:0] model_rd(input logic [29:0] a);
    if (!in_rng(a)) return NOP;
    if (model.exists(int'(a))) return model[int'(a)];
    return NOP;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_fetch(input string tag);
    if (fetch_q.size() == 0) check_val({tag, "_sb"}, 32'(fetch_q.size()), 32'd1);
    else check_val(tag, fetch_data, fetch_q.pop_front());
  endtask

  task automatic fetch_one(input logic [29:0] a, input string tag);
    fetch_addr = a;
    fetch_q.push_back(model_rd(a));
    tick();
    pop_fetch(tag);
  endtask

  // Counts edges from reset release until init_done, checking NOP output meanwhile.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    fetch_addr = 30'h0;
    while (n < 5000) begin
      tick();
      n++;
      check_val({tag, "_fill_nop"}, fetch_data, NOP);
      if (init_done) break;
    end
    check_val({tag, "_init_latency"}, 32'(n), 32'(WORDS));
  endtask

  task automatic dbg_op(input logic wr, input logic [29:0] a, input logic [31:0] wd,
                        input logic [29:0] faddr, input int hold, input string tag);
    logic [31:0] exp_rd;
    exp_rd    = 32'h0;
    dbg_req   = 1'b1;
    dbg_wr    = wr;
    dbg_addr  = a;
    dbg_wdata = wd;
    if (!wr) dbg_q.push_back(in_rng(a) ? model_rd(a) : 32'h0);
    tick();
    check_val({tag, "_ack_n1"}, 32'(dbg_ack), 32'd0);
    fetch_addr = faddr;
    if (wr && in_rng(a)) model[int'(a)] = wd;
    fetch_q.push_back(model_rd(faddr));
    tick();
    check_val({tag, "_ack_n2"}, 32'(dbg_ack), 32'd1);
    pop_fetch({tag, "_fetch"});
    if (!wr) begin
      exp_rd = dbg_q.pop_front();
      check_val({tag, "_rdata"}, dbg_rdata, exp_rd);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check_val({tag, "_ack_held"}, 32'(dbg_ack), 32'd0);
      if (!wr) check_val({tag, "_rdata_held"}, dbg_rdata, exp_rd);
    end
    dbg_req = 1'b0;
    tick();
    check_val({tag, "_ack_drop"}, 32'(dbg_ack), 32'd0);
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_addr = 30'h0;
    dbg_req    = 1'b0;
    dbg_wr     = 1'b0;
    dbg_addr   = 30'h0;
    dbg_wdata  = 32'h0;
    #1;
    check_val("rst_fetch", fetch_data, NOP);
    check_val("rst_rdata", dbg_rdata, 32'h0);
    check_val("rst_ack", 32'(dbg_ack), 32'd0);
    check_val("rst_init", 32'(init_done), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_init("t1");
    fetch_one(30'h0, "t1_fetch0");

    dbg_op(1'b1, 30'h10, 32'h12345678, 30'h0, 0, "t2_wr");
    fetch_one(30'h10, "t2_fetch");

    dbg_op(1'b1, 30'h20, 32'hcafef00d, 30'h20, 0, "t3_collide");
    fetch_one(30'h20, "t3_fetch");

    fetch_one(30'h3fffffff, "t4_fetch_oor");
    dbg_op(1'b1, 30'h1010, 32'hdeadbeef, 30'h10, 0, "t4_wr_oor");
    fetch_one(30'h10, "t4_fetch_alias");
    dbg_op(1'b0, 30'h20000000, 32'h0, 30'h0, 0, "t4_rd_oor");

    dbg_op(1'b0, 30'h10, 32'h0, 30'h0, 8, "t5_rd_hold");
    dbg_op(1'b0, 30'h10, 32'h0, 30'h10, 0, "t5_rd_again");
    dbg_op(1'b0, 30'h20, 32'h0, 30'h3fffffff, 0, "t5_rd_20");

    dbg_req  = 1'b1;
    dbg_wr   = 1'b0;
    dbg_addr = 30'h10;
    tick();
    tick();
    check_val("t6_ack_before", 32'(dbg_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t6_ack_rst", 32'(dbg_ack), 32'd0);
    check_val("t6_init_rst", 32'(init_done), 32'd0);
    check_val("t6_fetch_rst", fetch_data, NOP);
    check_val("t6_rdata_rst", dbg_rdata, 32'h0);
    dbg_req = 1'b0;
    model.delete();
    fetch_q.delete();
    dbg_q.delete();
    tick();
    rst_n = 1'b1;
    wait_init("t6");
    dbg_op(1'b0, 30'h10, 32'h0, 30'h10, 0, "t6_rd_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
